// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ID/EX ALU control unit: ALU codes, funct codes,
// main-decoder ALU classes and the multiply/divide sequencer state type.
package alu_ctrl_pkg;

    // ALU control codes (4-bit base encoding, zero-extended to CTRL_W)
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_MULT = 4'b1101;
    localparam logic [3:0] ALU_DIV  = 4'b1110;

    // R-type funct field values
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    // Main-decoder ALU classes
    localparam logic [1:0] AOP_ADD  = 2'b00;
    localparam logic [1:0] AOP_SUB  = 2'b01;
    localparam logic [1:0] AOP_RTYP = 2'b10;
    localparam logic [1:0] AOP_ADD2 = 2'b11;

    // Multiply/divide sequencer state
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/alu_ctrl_unit_md_busy_timer.sv
// Multiply/divide occupancy timer: IDLE/BUSY FSM with a load/decrement
// counter. Present only when MIPS_MULDIV_EN is defined.
`ifdef MIPS_MULDIV_EN
module md_busy_timer
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             done
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // State, counter and registered done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next state: load on launch, count down while busy, flush wins
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (load) begin
                    state_d = MD_BUSY;
                    cnt_d   = load_val;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
        if (flush) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
        end
        // Done pulses in the last busy cycle (counter at zero)
        done_d = (state_d == MD_BUSY) && (cnt_d == '0);
    end

    assign busy = (state_q == MD_BUSY);
    assign done = done_q;

endmodule
`endif

// File: rtl/alu_ctrl_unit.sv
// ALU / jump-register control unit at the ID/EX boundary. Decodes
// {alu_op, funct} into a registered EX control word and sequences
// multi-cycle MULT/DIV occupancy when MIPS_MULDIV_EN is defined.
module alu_ctrl_unit
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W  = 4,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic              flush,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_alu_ctrl,
    output logic              ex_jr,
    output logic              ex_illegal,
    output logic              ex_md_start,
    output logic              md_busy,
    output logic              md_done
);

    // Reject unusable parameterisations at elaboration
    if (CTRL_W < 4 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_param_check
        $error("alu_ctrl_unit: CTRL_W must be >= 4, latencies >= 1");
    end

    logic [3:0] code_c;
    logic       jr_c;
    logic       illegal_c;
    logic       is_md;
    logic       accept;
`ifdef MIPS_MULDIV_EN
    logic       md_mul_c;
    logic       md_div_c;
`endif

    // Combinational decode of the incoming instruction
    always_comb begin
        code_c    = ALU_ADD;
        jr_c      = 1'b0;
        illegal_c = 1'b0;
`ifdef MIPS_MULDIV_EN
        md_mul_c  = 1'b0;
        md_div_c  = 1'b0;
`endif
        case (alu_op)
            AOP_ADD, AOP_ADD2: code_c = ALU_ADD;
            AOP_SUB:           code_c = ALU_SUB;
            default: begin
                case (funct)
                    F_ADD:  code_c = ALU_ADD;
                    F_SUB:  code_c = ALU_SUB;
                    F_AND:  code_c = ALU_AND;
                    F_OR:   code_c = ALU_OR;
                    F_XOR:  code_c = ALU_XOR;
                    F_NOR:  code_c = ALU_NOR;
                    F_SLT:  code_c = ALU_SLT;
                    F_SLTU: code_c = ALU_SLTU;
                    F_SLL:  code_c = ALU_SLL;
                    F_SRL:  code_c = ALU_SRL;
                    F_SRA:  code_c = ALU_SRA;
                    F_JR: begin
                        code_c = ALU_ADD;
                        jr_c   = 1'b1;
                    end
`ifdef MIPS_MULDIV_EN
                    F_MULT, F_MULTU: begin
                        code_c   = ALU_MULT;
                        md_mul_c = 1'b1;
                    end
                    F_DIV, F_DIVU: begin
                        code_c   = ALU_DIV;
                        md_div_c = 1'b1;
                    end
`endif
                    default: begin
                        code_c    = ALU_ADD;
                        illegal_c = 1'b1;
                    end
                endcase
            end
        endcase
    end

`ifdef MIPS_MULDIV_EN
    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    logic [CNT_W-1:0] load_val_c;

    assign is_md      = md_mul_c | md_div_c;
    assign load_val_c = md_div_c ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

    md_busy_timer #(
        .CNT_W (CNT_W)
    ) u_md_busy_timer (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .load     (accept & is_md),
        .load_val (load_val_c),
        .busy     (md_busy),
        .done     (md_done)
    );

    assign in_ready = ~md_busy;
`else
    assign is_md    = 1'b0;
    assign in_ready = 1'b1;
    assign md_busy  = 1'b0;
    assign md_done  = 1'b0;
`endif

    // Flush cancels any coincident handshake
    assign accept = in_valid & in_ready & ~flush;

    // EX-stage control register; fields hold on non-accept cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_alu_ctrl <= '0;
            ex_jr       <= 1'b0;
            ex_illegal  <= 1'b0;
            ex_md_start <= 1'b0;
        end else begin
            ex_valid    <= accept;
            ex_md_start <= accept & is_md;
            if (accept) begin
                ex_alu_ctrl <= CTRL_W'(code_c);
                ex_jr       <= jr_c;
                ex_illegal  <= illegal_c;
            end
        end
    end

endmodule

// File: doc/alu_ctrl_unit.md
# alu_ctrl_unit

Registered ALU/jump-register control unit for the MIPS32 pipeline, sitting at the ID/EX boundary. It decodes `{alu_op, funct}` into the EX-stage ALU control word and JR flag with one cycle of latency. It also sequences multi-cycle MULT/DIV operations, back-pressuring the ID stage through a ready/valid handshake while the multiply/divide unit is busy.

## Interface
- `CTRL_W`, 4: ALU control width; must be ≥ 4; codes zero-extended into upper bits.
- `MUL_LAT`, 4: MULT/MULTU occupancy in cycles; must be ≥ 1.
- `DIV_LAT`, 32: DIV/DIVU occupancy in cycles; must be ≥ 1.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  ID presents a decoded instruction.
- `in_ready`  out  1  unit accepts this cycle; accept = `in_valid & in_ready`.
- `alu_op`  in  2  main-decoder ALU class.
- `funct`  in  6  R-type function field.
- `flush`  in  1  cancel EX-stage contents and any MD operation.
- `ex_valid`  out  1  EX-stage control is valid.
- `ex_alu_ctrl`  out  CTRL_W  ALU control word.
- `ex_jr`  out  1  jump-register select.
- `ex_illegal`  out  1  unknown R-type funct.
- `ex_md_start`  out  1  MULT/DIV launched this cycle.
- `md_busy`  out  1  MD operation in progress.
- `md_done`  out  1  one-cycle pulse, HI/LO write enable.

## Operation
- Decode (alu_op 00/11 → ADD 0010; 01 → SUB 0110; 10 → by funct): 100000 ADD 0010, 100010 SUB 0110, 100100 AND 0000, 100101 OR 0001, 100110 XOR 0011, 100111 NOR 1100, 101010 SLT 0111, 101011 SLTU 1011, 000000 SLL 1000, 000010 SRL 1001, 000011 SRA 1010, 011000/011001 MULT 1101, 011010/011011 DIV 1110, 001000 JR (ctrl 0010, `ex_jr`=1).
- alu_op 10 with any other funct: ctrl 0010, `ex_illegal`=1.
- `ex_jr` is 1 only for alu_op 10 & funct 001000.
- FSM IDLE/BUSY. IDLE: accepting an MD funct → BUSY, counter loaded with LAT−1 (MUL_LAT for 01100x, DIV_LAT for 01101x). BUSY: counter decrements; at counter 0 `md_done`=1 and next state IDLE.
- `in_ready` = (state == IDLE); `md_busy` = (state == BUSY).
- On a non-accept cycle `ex_valid` clears to 0; EX fields hold but are don't-care.
- Counter width: `$clog2(max(MUL_LAT,DIV_LAT))`, minimum 1.

## Timing
- Reset: `ex_valid`, `ex_jr`, `ex_illegal`, `ex_md_start`, `md_busy`, `md_done` = 0; `ex_alu_ctrl` = 0; `in_ready` = 1; IDLE; counter 0.
- Accept at edge T → EX outputs valid in cycle T+1 (1-cycle latency).
- MD accepted at edge T: `ex_md_start`=1 and `md_busy`=1 in T+1; `md_done` in T+LAT; `in_ready`=1 again in T+LAT+1.
- LAT=1: `md_done` coincides with `ex_md_start`.
- `flush` beats accept: same edge clears `ex_valid`, returns to IDLE, counter 0; no `md_done`; a coincident `in_valid` is dropped.
- Reset mid-operation behaves as flush plus output reset.

## Configuration
- `MIPS_MULDIV_EN` defined: MD decode, FSM and counter present as above.
- Undefined: MD functs decode as illegal (ctrl 0010); `in_ready` tied 1; `md_busy`, `md_done`, `ex_md_start` tied 0; MUL_LAT/DIV_LAT ignored.

## Structure
- Package `alu_ctrl_pkg`: ALU control code constants, funct constants, alu_op class constants, FSM state enum.
- Sub-module `md_busy_timer`: load/decrement counter plus IDLE/BUSY FSM, exporting `busy`/`done`; compiled only under `MIPS_MULDIV_EN`.

## Test plan
- Reset, then alu_op=10 funct=100000/100010/100100/100101/101010 back-to-back → ctrl 0010/0110/0000/0001/0111 one cycle after each accept, `in_ready` held 1.
- alu_op=10 funct=001000 → `ex_jr`=1, ctrl 0010; alu_op=00 funct=001000 → `ex_jr`=0; funct=111111 → `ex_illegal`=1.
- MULT at edge T, MUL_LAT=4, `in_valid` held → `in_ready` low T+1..T+4, `md_done` only at T+4, next accept at end of T+5.
- DIV (DIV_LAT=32) with `flush` in cycle T+10 → `md_busy` 0 and `in_ready` 1 at T+11, no `md_done` pulse ever.
- `flush` and `in_valid` (ADD) same cycle → `ex_valid` 0 next cycle; `reset` mid-MULT → all outputs at reset values next cycle.
- Build without `MIPS_MULDIV_EN`: MULT → `ex_illegal`=1, `md_busy` never 1.
